// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480 VGA timing constants, sync windows and the rgb888 pixel type
// shared by the scan mixer and its delay line.
package vga_timing_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int SPR_LAT  = 2;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    localparam rgb888_t BG_RGB = 24'h000040;
endpackage

// File: rtl/vga_sig_delay.sv
// vga_sig_delay: DEPTH-stage shift register that holds while i_en is low and clears
// synchronously to RST_VAL while reset is low.
module vga_sig_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
        end else if (i_en) begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/vga_scan_mixer.sv
// vga_scan_mixer: VGA timing generator and sprite-over-background pixel mixer.
// Define VGA_MIXER_CHECKER_BG_EN for a 16x16 checkerboard background instead of a flat one.
module vga_scan_mixer #(
    parameter int          H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int          H_FP     = vga_timing_pkg::H_FP,
    parameter int          H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int          H_BP     = vga_timing_pkg::H_BP,
    parameter int          V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int          V_FP     = vga_timing_pkg::V_FP,
    parameter int          V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int          V_BP     = vga_timing_pkg::V_BP,
    parameter int          SPR_LAT  = vga_timing_pkg::SPR_LAT,
    parameter logic [23:0] BG_RGB   = vga_timing_pkg::BG_RGB
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [9:0] oVGA_X,
    output logic [8:0] oVGA_Y,
    input  logic       iSprVal,
    input  logic [7:0] iSprR,
    input  logic [7:0] iSprG,
    input  logic [7:0] iSprB,
    output logic       oHS,
    output logic       oVS,
    output logic       oBLANK_N,
    output logic [7:0] oR,
    output logic [7:0] oG,
    output logic [7:0] oB,
    output logic       oFrameStart
);
    import vga_timing_pkg::*;

    localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_LO  = H_ACTIVE + H_FP;
    localparam int HS_HI  = HS_LO + H_SYNC;
    localparam int VS_LO  = V_ACTIVE + V_FP;
    localparam int VS_HI  = VS_LO + V_SYNC;
`ifdef VGA_MIXER_CHECKER_BG_EN
    localparam int DW = 5;
`else
    localparam int DW = 3;
`endif

    logic [9:0]    r_h, r_v;
    logic          r_hs, r_vs, r_blank_n, r_fs;
    rgb888_t       r_rgb;
    logic          w_h_last, w_v_last, w_h_act, w_v_act;
    logic          w_hs_n, w_vs_n, w_act_d, w_hs_d, w_vs_d;
    logic [DW-1:0] w_dly_in, w_dly_out;
    rgb888_t       w_bg, w_spr, w_pix;

    assign w_h_last = r_h == 10'(H_TOT - 1);
    assign w_v_last = r_v == 10'(V_TOT - 1);
    assign w_h_act  = r_h < 10'(H_ACTIVE);
    assign w_v_act  = r_v < 10'(V_ACTIVE);
    assign w_hs_n   = !(r_h >= 10'(HS_LO) && r_h < 10'(HS_HI));
    assign w_vs_n   = !(r_v >= 10'(VS_LO) && r_v < 10'(VS_HI));
    assign oVGA_X   = w_h_act ? r_h : '0;
    assign oVGA_Y   = w_v_act ? r_v[8:0] : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (enable) begin
            r_h <= w_h_last ? '0 : r_h + 10'd1;
            if (w_h_last) r_v <= w_v_last ? '0 : r_v + 10'd1;
        end
    end

    // Timing bits ride alongside the sprite pipeline so they line up with iSpr*.
`ifdef VGA_MIXER_CHECKER_BG_EN
    assign w_dly_in = {r_h[4], r_v[4], w_h_act && w_v_act, w_hs_n, w_vs_n};
    assign w_bg     = (w_dly_out[4] ^ w_dly_out[3]) ? ~BG_RGB : BG_RGB;
`else
    assign w_dly_in = {w_h_act && w_v_act, w_hs_n, w_vs_n};
    assign w_bg     = BG_RGB;
`endif

    vga_sig_delay #(
        .WIDTH  (DW),
        .DEPTH  (SPR_LAT),
        .RST_VAL(DW'(3'b011))
    ) u_dly (
        .clk  (clk),
        .reset(reset),
        .i_en (enable),
        .i_d  (w_dly_in),
        .o_q  (w_dly_out)
    );

    assign w_act_d = w_dly_out[2];
    assign w_hs_d  = w_dly_out[1];
    assign w_vs_d  = w_dly_out[0];
    assign w_spr   = {iSprR, iSprG, iSprB};
    assign w_pix   = !w_act_d ? '0 : iSprVal ? w_spr : w_bg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_rgb     <= '0;
            r_fs      <= 1'b0;
        end else begin
            r_fs      <= enable && r_h == '0 && r_v == 10'(V_ACTIVE);
            r_blank_n <= enable && w_act_d;
            r_rgb     <= enable ? w_pix : '0;
            if (enable) begin
                r_hs <= w_hs_d;
                r_vs <= w_vs_d;
            end
        end
    end

    assign oHS         = r_hs;
    assign oVS         = r_vs;
    assign oBLANK_N    = r_blank_n;
    assign oR          = r_rgb.r;
    assign oG          = r_rgb.g;
    assign oB          = r_rgb.b;
    assign oFrameStart = r_fs;
endmodule

// File: tb/tb_vga_scan_mixer.sv
// tb_vga_scan_mixer: directed vectors plus hand sequences for vga_scan_mixer.
// Vertical timing is shortened (52 visible lines, 58 total) so a whole frame fits the run.
module tb_vga_scan_mixer;
    localparam int HT = 800;
    localparam int VA = 52;
    localparam int VT = 58;
`ifdef VGA_MIXER_CHECKER_BG_EN
    localparam int CHK = 16;
`else
    localparam int CHK = 0;
`endif

    logic       clk = 1'b0, reset = 1'b0, enable = 1'b1;
    logic [9:0] oVGA_X;
    logic [8:0] oVGA_Y;
    logic       iSprVal;
    logic [7:0] iSprR, iSprG, iSprB, oR, oG, oB;
    logic       oHS, oVS, oBLANK_N, oFrameStart;
    logic [9:0] s_x1 = '0, s_x2 = '0;
    logic [8:0] s_y1 = '0, s_y2 = '0;
    logic       junk = 1'b0, coord = 1'b0, rect;
    int         n_chk = 0, n_fail = 0, cyc = 0;

    typedef struct {
        int          x;
        int          y;
        logic        junk;
        logic        blank_n;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    vga_scan_mixer #(.V_ACTIVE(VA), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .oVGA_X(oVGA_X), .oVGA_Y(oVGA_Y),
        .iSprVal(iSprVal), .iSprR(iSprR), .iSprG(iSprG), .iSprB(iSprB),
        .oHS(oHS), .oVS(oVS), .oBLANK_N(oBLANK_N),
        .oR(oR), .oG(oG), .oB(oB), .oFrameStart(oFrameStart)
    );

    // Sprite stub with a 2-cycle coordinate pipeline that stalls with the scan.
    always @(posedge clk) begin
        if (enable) begin
            s_x1 <= oVGA_X;
            s_x2 <= s_x1;
            s_y1 <= oVGA_Y;
            s_y2 <= s_y1;
        end
    end

    always_comb begin
        rect    = s_y2 == 9'd50 && s_x2 >= 10'd100 && s_x2 <= 10'd109;
        iSprVal = rect || junk || coord;
        {iSprR, iSprG, iSprB} = rect ? 24'hFF0000 : coord ? {8'h11, 6'd0, s_x2} : 24'hFFFFFF;
    end

    function automatic logic [23:0] bg(input int x, input int y);
        return (((x ^ y) & CHK) != 0) ? 24'hFFFFBF : 24'h000040;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int tgt, n, fs_n, fs_at, bad;
        tbl.push_back('{0,   2,  1'b0, 1'b1, bg(0, 2),   1'b1, 1'b1});
        tbl.push_back('{16,  2,  1'b0, 1'b1, bg(16, 2),  1'b1, 1'b1});
        tbl.push_back('{639, 2,  1'b0, 1'b1, bg(639, 2), 1'b1, 1'b1});
        tbl.push_back('{640, 2,  1'b0, 1'b0, 24'h0,      1'b1, 1'b1});
        tbl.push_back('{655, 2,  1'b0, 1'b0, 24'h0,      1'b1, 1'b1});
        tbl.push_back('{656, 2,  1'b0, 1'b0, 24'h0,      1'b0, 1'b1});
        tbl.push_back('{751, 2,  1'b0, 1'b0, 24'h0,      1'b0, 1'b1});
        tbl.push_back('{752, 2,  1'b0, 1'b0, 24'h0,      1'b1, 1'b1});
        tbl.push_back('{16,  16, 1'b0, 1'b1, bg(16, 16), 1'b1, 1'b1});
        tbl.push_back('{99,  50, 1'b0, 1'b1, bg(99, 50), 1'b1, 1'b1});
        tbl.push_back('{100, 50, 1'b0, 1'b1, 24'hFF0000, 1'b1, 1'b1});
        tbl.push_back('{109, 50, 1'b0, 1'b1, 24'hFF0000, 1'b1, 1'b1});
        tbl.push_back('{110, 50, 1'b0, 1'b1, bg(110, 50), 1'b1, 1'b1});
        tbl.push_back('{700, 50, 1'b1, 1'b0, 24'h0,      1'b0, 1'b1});
        tbl.push_back('{100, 51, 1'b0, 1'b1, bg(100, 51), 1'b1, 1'b1});

        step(5);
        chk("rst_hs", oHS, 1);
        chk("rst_vs", oVS, 1);
        chk("rst_blank", oBLANK_N, 0);
        chk("rst_rgb", {oR, oG, oB}, 0);
        chk("rst_fs", oFrameStart, 0);
        reset = 1'b1;
        cyc = 0;
        chk("rel_x0", oVGA_X, 0);
        chk("rel_y0", oVGA_Y, 0);
        step(1);
        chk("rel_x1", oVGA_X, 1);
        step(1);
        chk("pin2_blank", oBLANK_N, 0);
        step(1);
        chk("pin3_blank", oBLANK_N, 1);
        chk("pin3_rgb", {oR, oG, oB}, bg(0, 0));

        while (oHS && cyc < 1000) step(1);
        chk("hs_first_low", cyc, 659);
        n = 0;
        while (!oHS && n < 200) begin
            step(1);
            n++;
        end
        chk("hs_low_len", n, 96);

        foreach (tbl[i]) begin
            tgt = tbl[i].y * HT + tbl[i].x + 3;
            junk = tbl[i].junk;
            while (cyc < tgt) step(1);
            chk($sformatf("blank(%0d,%0d)", tbl[i].x, tbl[i].y), oBLANK_N, tbl[i].blank_n);
            chk($sformatf("rgb(%0d,%0d)", tbl[i].x, tbl[i].y), {oR, oG, oB}, tbl[i].rgb);
            chk($sformatf("hs(%0d,%0d)", tbl[i].x, tbl[i].y), oHS, tbl[i].hs);
            chk($sformatf("vs(%0d,%0d)", tbl[i].x, tbl[i].y), oVS, tbl[i].vs);
        end
        junk = 1'b0;

        fs_n = 0;
        fs_at = -1;
        while (cyc < VA * HT + 10) begin
            step(1);
            if (oFrameStart) begin
                fs_n++;
                fs_at = cyc;
            end
        end
        chk("fs_count", fs_n, 1);
        chk("fs_cycle", fs_at, VA * HT + 1);

        junk = 1'b1;
        bad = 0;
        while (oVS && cyc < 50000) begin
            step(1);
            if (oBLANK_N || {oR, oG, oB} != 24'h0) bad++;
            if (oFrameStart) fs_n++;
        end
        chk("vs_first_low", cyc, 54 * HT + 3);
        n = 0;
        while (!oVS && n < 2000) begin
            step(1);
            n++;
            if (oBLANK_N || {oR, oG, oB} != 24'h0) bad++;
        end
        chk("vs_low_len", n, 1600);
        chk("vblank_junk_dark", bad, 0);
        junk = 1'b0;

        while (cyc < VT * HT) begin
            step(1);
            if (oFrameStart) fs_n++;
        end
        chk("fs_once_per_frame", fs_n, 1);
        chk("wrap_x0", oVGA_X, 0);
        chk("wrap_y0", oVGA_Y, 0);
        step(1);
        chk("wrap_x1", oVGA_X, 1);
        step(2);
        chk("wrap_pin_blank", oBLANK_N, 1);
        while (cyc < VT * HT + HT + 5) step(1);
        chk("wrap_y1", oVGA_Y, 1);
        chk("wrap_y1_x", oVGA_X, 5);

        coord = 1'b1;
        while (cyc < VT * HT + 3 * HT + 300) step(1);
        chk("en_x", oVGA_X, 300);
        chk("en_y", oVGA_Y, 3);
        chk("en_pin_before", {oR, oG, oB}, 24'h110129);
        enable = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            chk($sformatf("hold_x%0d", k), oVGA_X, 300);
            chk($sformatf("hold_blank%0d", k), oBLANK_N, 0);
            if ({oR, oG, oB} != 24'h0 || !oHS || !oVS || oFrameStart) bad++;
        end
        chk("hold_pins_quiet", bad, 0);
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk($sformatf("resume_rgb%0d", k), {oR, oG, oB}, {8'h11, 6'd0, 10'(298 + k)});
            chk($sformatf("resume_blank%0d", k), oBLANK_N, 1);
        end
        coord = 1'b0;

        reset = 1'b0;
        step(1);
        chk("mid_rst_x", oVGA_X, 0);
        chk("mid_rst_blank", oBLANK_N, 0);
        chk("mid_rst_rgb", {oR, oG, oB}, 0);
        reset = 1'b1;
        step(1);
        chk("mid_rel_x1", oVGA_X, 1);
        chk("mid_rel_y0", oVGA_Y, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
